// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg -- ID/EX pipeline register for a classic 5-stage MIPS-style core.
//
// Captures the decoded instruction (PC+4, operand data, sign-extended
// immediate, register numbers, control word) on each rising clk edge and
// presents it to the execute stage. Also produces the combinational
// load-use hazard request used by the hazard unit to stall decode.
//
// Update priority per edge: flush (load a bubble) > stall (hold) > load.
// An invalid decode slot is captured with a zeroed control word so it can
// never write the register file or memory.
//
// Optional feature (compile-time macro IDEX_WB_BYPASS_EN):
//   When defined, operand data is bypassed from the writeback stage at
//   capture time if writeback targets the same non-zero register. When
//   undefined, the wb_* ports are present but ignored.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   stall, flush          hold contents / load a bubble
//   id_valid              decode-stage instruction valid
//   id_pc4, id_rs_data,
//   id_rt_data, id_imm    decode data values (DATA_W)
//   id_rs, id_rt, id_rd   register numbers (5)
//   id_ctrl               {RegWrite, MemtoReg, MemRead, MemWrite, Branch,
//                          ALUSrc, RegDst, ALUOp[1:0]}
//   wb_regwrite, wb_rd,
//   wb_data               writeback-stage register write
//   ex_*                  registered copies of the id_* fields
//   load_use_hazard       combinational load-use stall request
// -----------------------------------------------------------------------------

// Per-operand capture path: selects the value an operand register should
// take on a load, applying the writeback bypass when it is compiled in.
module id_ex_opnd #(
    parameter int DATA_W = 32
) (
    input  logic [4:0]        id_reg,
    input  logic [DATA_W-1:0] id_data,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] cap_data
);
`ifdef IDEX_WB_BYPASS_EN
    // Register 0 is hardwired; a write to it must never be forwarded.
    logic wb_hit;
    assign wb_hit   = wb_regwrite & (wb_rd != 5'd0) & (wb_rd == id_reg);
    assign cap_data = wb_hit ? wb_data : id_data;
`else
    // Writeback inputs are intentionally unused in this build.
    logic unused_wb;
    assign unused_wb = &{1'b0, wb_regwrite, wb_rd, wb_data, id_reg};
    assign cap_data  = id_data;
`endif
endmodule

module id_ex_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [8:0]        id_ctrl,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [8:0]        ex_ctrl,
    output logic              load_use_hazard
);
    // Bit position of MemRead inside the control word.
    localparam int CTRL_MEMREAD = 6;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [8:0]        ctrl;
    } idex_t;

    idex_t ex_q;
    idex_t ex_d;

    // Operand index 0 = rs, 1 = rt.
    logic [1:0][4:0]        op_reg;
    logic [1:0][DATA_W-1:0] op_data;
    logic [1:0][DATA_W-1:0] op_cap;

    assign op_reg  = {id_rt, id_rs};
    assign op_data = {id_rt_data, id_rs_data};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_opnd
            id_ex_opnd #(.DATA_W(DATA_W)) u_opnd (
                .id_reg      (op_reg[g]),
                .id_data     (op_data[g]),
                .wb_regwrite (wb_regwrite),
                .wb_rd       (wb_rd),
                .wb_data     (wb_data),
                .cap_data    (op_cap[g])
            );
        end
    endgenerate

    // Load value; ctrl is zeroed for an invalid slot so a bubble is inert.
    always_comb begin
        ex_d         = '0;
        ex_d.valid   = id_valid;
        ex_d.pc4     = id_pc4;
        ex_d.rs_data = op_cap[0];
        ex_d.rt_data = op_cap[1];
        ex_d.imm     = id_imm;
        ex_d.rs      = id_rs;
        ex_d.rt      = id_rt;
        ex_d.rd      = id_rd;
        ex_d.ctrl    = id_valid ? id_ctrl : 9'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else if (flush) begin
            ex_q <= '0;
        end else if (!stall) begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid   = ex_q.valid;
    assign ex_pc4     = ex_q.pc4;
    assign ex_rs_data = ex_q.rs_data;
    assign ex_rt_data = ex_q.rt_data;
    assign ex_imm     = ex_q.imm;
    assign ex_rs      = ex_q.rs;
    assign ex_rt      = ex_q.rt;
    assign ex_rd      = ex_q.rd;
    assign ex_ctrl    = ex_q.ctrl;

    // A load in EX whose destination (rt) feeds the instruction in ID.
    // Purely a function of EX state and ID inputs; reset clears ex_q, so
    // this is low throughout reset.
    assign load_use_hazard = ex_q.valid & ex_q.ctrl[CTRL_MEMREAD] & id_valid &
                             (ex_q.rt != 5'd0) &
                             ((ex_q.rt == id_rs) | (ex_q.rt == id_rt));
endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0, flush = 1'b0, id_valid = 1'b0;
    logic [DW-1:0] id_pc4 = '0, id_rs_data = '0, id_rt_data = '0, id_imm = '0;
    logic [4:0]    id_rs = '0, id_rt = '0, id_rd = '0;
    logic [8:0]    id_ctrl = '0;
    logic          wb_regwrite = 1'b0;
    logic [4:0]    wb_rd = '0;
    logic [DW-1:0] wb_data = '0;
    logic          ex_valid;
    logic [DW-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]    ex_rs, ex_rt, ex_rd;
    logic [8:0]    ex_ctrl;
    logic          load_use_hazard;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    id_ex_reg #(.DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc4(id_pc4), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_ctrl(id_ctrl), .wb_regwrite(wb_regwrite),
        .wb_rd(wb_rd), .wb_data(wb_data), .ex_valid(ex_valid), .ex_pc4(ex_pc4),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .load_use_hazard(load_use_hazard)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Expected EX contents held as plain variables; rebuilt from the rules.
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_pc4 = '0, m_rsd = '0, m_rtd = '0, m_imm = '0;
    logic [4:0]    m_rs = '0, m_rt = '0, m_rd = '0;
    logic [8:0]    m_ctrl = '0;

    function automatic logic [DW-1:0] pick(input logic [4:0] r, input logic [DW-1:0] d);
`ifdef IDEX_WB_BYPASS_EN
        if (wb_regwrite && wb_rd != 0 && wb_rd == r) return wb_data;
`endif
        return d;
    endfunction

    function automatic logic model_hazard();
        return m_valid && m_ctrl[6] && id_valid && m_rt != 0 &&
               (m_rt == id_rs || m_rt == id_rt);
    endfunction

    task automatic model_clear();
        m_valid = 0; m_pc4 = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
        m_rs = 0; m_rt = 0; m_rd = 0; m_ctrl = 0;
    endtask

    always @(negedge rst_n) model_clear();

    always @(posedge clk) begin
        if (!rst_n || flush) model_clear();
        else if (!stall) begin
            m_valid = id_valid;
            m_pc4   = id_pc4;
            m_rsd   = pick(id_rs, id_rs_data);
            m_rtd   = pick(id_rt, id_rt_data);
            m_imm   = id_imm;
            m_rs    = id_rs; m_rt = id_rt; m_rd = id_rd;
            m_ctrl  = id_valid ? id_ctrl : 9'd0;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_ctrl} !==
                {m_valid, m_pc4, m_rsd, m_rtd, m_imm, m_rs, m_rt, m_rd, m_ctrl}) begin
                errors++;
                $display("FAIL model_ex t=%0t got v=%b pc4=%h rs=%h rt=%h imm=%h r=%0d/%0d/%0d c=%h want v=%b pc4=%h rs=%h rt=%h imm=%h r=%0d/%0d/%0d c=%h",
                    $time, ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd, ex_ctrl,
                    m_valid, m_pc4, m_rsd, m_rtd, m_imm, m_rs, m_rt, m_rd, m_ctrl);
            end
            checks++;
            if (load_use_hazard !== model_hazard()) begin
                errors++;
                $display("FAIL model_hazard t=%0t got %b want %b", $time, load_use_hazard, model_hazard());
            end
        end
    end

    // ---------------- literal checks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [DW-1:0] pc4, input logic [DW-1:0] rsd,
                          input logic [DW-1:0] rtd, input logic [DW-1:0] imm,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [8:0] ctrl);
        id_valid = v; id_pc4 = pc4; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_rs = rs; id_rt = rt; id_rd = rd; id_ctrl = ctrl;
    endtask

    initial begin
        // Reset with busy inputs
        set_id(1, 32'h40, 32'h11, 32'h22, 32'h33, 5'd4, 5'd4, 5'd4, 9'h1FF);
        chk_en = 1;
        step(); step();
        check("rst_valid", {63'd0, ex_valid}, 64'd0);
        check("rst_ctrl", {55'd0, ex_ctrl}, 64'd0);
        check("rst_hazard", {63'd0, load_use_hazard}, 64'd0);
        rst_n = 1;

        // Plain load
        set_id(1, 32'h104, 32'hA5A5_0001, 32'h5A5A_0002, 32'hFFFF_8000, 5'd1, 5'd2, 5'd3, 9'h1E3);
        step();
        check("load_imm", {32'd0, ex_imm}, 64'hFFFF_8000);
        check("load_ctrl", {55'd0, ex_ctrl}, 64'h1E3);
        check("load_pc4", {32'd0, ex_pc4}, 64'h104);
        check("load_valid", {63'd0, ex_valid}, 64'd1);
        check("load_rsd", {32'd0, ex_rs_data}, 64'hA5A5_0001);

        // Stall 3 cycles with changing inputs
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 32'h200 + i, i, i, i, 5'(i + 9), 5'(i + 10), 5'(i + 11), 9'h0F0);
            step();
            check("stall_imm", {32'd0, ex_imm}, 64'hFFFF_8000);
            check("stall_pc4", {32'd0, ex_pc4}, 64'h104);
        end
        // Flush wins over stall
        flush = 1;
        step();
        check("flush_valid", {63'd0, ex_valid}, 64'd0);
        check("flush_ctrl", {55'd0, ex_ctrl}, 64'd0);
        check("flush_rd", {59'd0, ex_rd}, 64'd0);
        stall = 0; flush = 0;

        // Invalid slot loads a zero control word
        set_id(0, 32'h300, 1, 2, 3, 5'd7, 5'd8, 5'd9, 9'h1FF);
        step();
        check("inv_ctrl", {55'd0, ex_ctrl}, 64'd0);
        check("inv_rd", {59'd0, ex_rd}, 64'd9);

        // Load-use: lw $8 in EX
        set_id(1, 32'h400, 0, 0, 4, 5'd2, 5'd8, 5'd8, 9'h1C8);
        step();
        set_id(1, 32'h404, 0, 0, 0, 5'd8, 5'd9, 5'd10, 9'h122);
        #1 check("lu_rs", {63'd0, load_use_hazard}, 64'd1);
        stall = 1; flush = 1;
        #1 check("lu_stall_flush", {63'd0, load_use_hazard}, 64'd1);
        stall = 0; flush = 0;
        id_rs = 5'd3; id_rt = 5'd8;
        #1 check("lu_rt", {63'd0, load_use_hazard}, 64'd1);
        id_valid = 0;
        #1 check("lu_idinv", {63'd0, load_use_hazard}, 64'd0);
        id_valid = 1; id_rs = 5'd3; id_rt = 5'd4;
        #1 check("lu_nomatch", {63'd0, load_use_hazard}, 64'd0);
        // lw with rt=0, then ID reads $0
        set_id(1, 32'h408, 0, 0, 0, 5'd0, 5'd0, 5'd0, 9'h1C8);
        step();
        #1 check("lu_zero", {63'd0, load_use_hazard}, 64'd0);

        // Writeback bypass at capture
        wb_regwrite = 1; wb_rd = 5'd5; wb_data = 32'h1234_5678;
        set_id(1, 32'h500, 32'h0, 32'h77, 0, 5'd5, 5'd6, 5'd1, 9'h102);
        step();
`ifdef IDEX_WB_BYPASS_EN
        check("byp_rs", {32'd0, ex_rs_data}, 64'h1234_5678);
`else
        check("byp_rs", {32'd0, ex_rs_data}, 64'h0);
`endif
        check("byp_rt_nohit", {32'd0, ex_rt_data}, 64'h77);
        wb_rd = 5'd0;
        set_id(1, 32'h504, 32'hAAAA, 32'hBBBB, 0, 5'd0, 5'd0, 5'd1, 9'h102);
        step();
        check("byp_rd0", {32'd0, ex_rs_data}, 64'hAAAA);
        // Stall with a matching writeback: contents must hold
        wb_rd = 5'd6; wb_data = 32'hDEAD_BEEF; stall = 1;
        set_id(1, 32'h508, 1, 2, 0, 5'd6, 5'd6, 5'd1, 9'h102);
        step();
        check("byp_stall", {32'd0, ex_rt_data}, 64'hBBBB);
        stall = 0; wb_regwrite = 0;

        // Async reset mid-stall/flush, between edges
        set_id(1, 32'h600, 5, 6, 7, 5'd1, 5'd2, 5'd3, 9'h1E3);
        step();
        stall = 1; flush = 1;
        rst_n = 0;
        #1;
        check("arst_valid", {63'd0, ex_valid}, 64'd0);
        check("arst_pc4", {32'd0, ex_pc4}, 64'd0);
        step();
        rst_n = 1; stall = 0; flush = 0;
        set_id(1, 32'h700, 9, 8, 7, 5'd4, 5'd5, 5'd6, 9'h0A1);
        step();
        check("post_rst_pc4", {32'd0, ex_pc4}, 64'h700);
        check("post_rst_ctrl", {55'd0, ex_ctrl}, 64'h0A1);

        // Mixed traffic checked by the model
        wb_rd = 5'd3; wb_data = 32'hC0DE_0000;
        for (int i = 0; i < 60; i++) begin
            set_id(1'($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom, $urandom,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom),
                   9'($urandom));
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            wb_regwrite = 1'($urandom);
            step();
        end

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
